// File: rtl/screen_sequencer_if.sv
// Signal bundle between the screen sequencer and its surroundings: buttons, game
// status, pixel coordinates, renderer colours and the committed display outputs.
interface screen_sequencer_if;
    logic       btn_start;
    logic       btn_pause;
    logic       player_dead;
    logic [9:0] xCoord;
    logic [9:0] yCoord;
    logic [7:0] rgb_start;
    logic [7:0] rgb_game;
    logic [7:0] rgb_over;
    logic [7:0] rgb;
    logic [1:0] screen;
    logic       game_en;
    logic       game_clr;

    modport master (
        output btn_start, btn_pause, player_dead, xCoord, yCoord,
               rgb_start, rgb_game, rgb_over,
        input  rgb, screen, game_en, game_clr
    );

    modport slave (
        input  btn_start, btn_pause, player_dead, xCoord, yCoord,
               rgb_start, rgb_game, rgb_over,
        output rgb, screen, game_en, game_clr
    );
endinterface

// File: rtl/screen_sequencer.sv
// Space Invaders screen controller: button debounce, START/PLAY/PAUSE/OVER
// sequencing committed at vertical blank, and the registered colour mux.
module screen_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned OVER_FRAMES     = 180,
    parameter int unsigned H_VIS           = 640,
    parameter int unsigned V_VIS           = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    screen_sequencer_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } screen_t;

    // Bit 0 = start button, bit 1 = pause button.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    press;
    logic [CW-1:0] dcnt [2];

    assign raw = {bus.btn_pause, bus.btn_start};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            press  <= '0;
            for (int unsigned i = 0; i < 2; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    press[i]  <= sync2[i];
                    dcnt[i]   <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
            end
        end
    end

    logic [9:0] prev_y;
    logic       tick;

    assign tick = (bus.yCoord == 10'(V_VIS)) && (prev_y != 10'(V_VIS));

    screen_t    screen_q, screen_d;
    screen_t    pend_q, pend_d, pend_c;
    logic [7:0] fcnt_q, fcnt_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic       blink_q, blink_d;
    logic       clr_q, clr_d;
    logic [7:0] rgb_q, rgb_d;

    always_comb begin
        screen_d = screen_q;
        pend_c   = pend_q;
        pend_d   = pend_q;
        fcnt_d   = fcnt_q;
        bcnt_d   = bcnt_q;
        blink_d  = blink_q;
        clr_d    = 1'b0;
        rgb_d    = '0;

        if (tick) begin
            if (screen_q == S_OVER && pend_q == S_OVER && fcnt_q == 8'(OVER_FRAMES - 1)) begin
                screen_d = S_START;
                pend_c   = S_START;
            end else begin
                screen_d = pend_q;
            end
            if (screen_d != screen_q)
                fcnt_d = '0;
            else if (fcnt_q != '1)
                fcnt_d = fcnt_q + 8'd1;
            clr_d = (screen_q == S_START) && (screen_d == S_PLAY);
            if (screen_d == S_PAUSE && screen_q != S_PAUSE) begin
                blink_d = 1'b1;
                bcnt_d  = '0;
            end else if (screen_d == S_PAUSE) begin
                if (bcnt_q == 8'(BLINK_FRAMES - 1)) begin
                    bcnt_d  = '0;
                    blink_d = ~blink_q;
                end else begin
                    bcnt_d = bcnt_q + 8'd1;
                end
            end
        end

        // Events see the post-commit screen; a pending death locks out everything else.
        pend_d = pend_c;
        if (bus.player_dead && screen_d == S_PLAY) begin
            pend_d = S_OVER;
        end else if (!(screen_d == S_PLAY && pend_c == S_OVER)) begin
            case (pend_c)
                S_START: if (press[0]) pend_d = S_PLAY;
                S_PLAY:  if (press[1]) pend_d = S_PAUSE;
                S_PAUSE: if (press[0] || press[1]) pend_d = S_PLAY;
                S_OVER:  if (press[0]) pend_d = S_START;
                default: pend_d = pend_c;
            endcase
        end

        if (bus.xCoord < 10'(H_VIS) && bus.yCoord < 10'(V_VIS)) begin
            case (screen_q)
                S_START: rgb_d = bus.rgb_start;
                S_PLAY:  rgb_d = bus.rgb_game;
                S_PAUSE: rgb_d = blink_q ? bus.rgb_game : 8'h00;
                S_OVER:  rgb_d = bus.rgb_over;
                default: rgb_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_y   <= '0;
            screen_q <= S_START;
            pend_q   <= S_START;
            fcnt_q   <= '0;
            bcnt_q   <= '0;
            blink_q  <= 1'b1;
            clr_q    <= 1'b0;
            rgb_q    <= '0;
        end else begin
            prev_y   <= bus.yCoord;
            screen_q <= screen_d;
            pend_q   <= pend_d;
            fcnt_q   <= fcnt_d;
            bcnt_q   <= bcnt_d;
            blink_q  <= blink_d;
            clr_q    <= clr_d;
            rgb_q    <= rgb_d;
        end
    end

    assign bus.rgb      = rgb_q;
    assign bus.screen   = screen_q;
    assign bus.game_en  = (screen_q == S_PLAY);
    assign bus.game_clr = clr_q;

endmodule
